// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory request target with programmable wait states and valid/ready response
module mem_responder #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_sys,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_write,
  output logic        rsp_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] cap_addr;
  logic [15:0] cap_wdata;
  logic        cap_write;
  logic [15:0] mem [DEPTH];

  logic          acc_now;
  logic [15:0]   acc_addr;
  logic [15:0]   acc_wdata;
  logic          acc_write;
  logic          acc_err;
  logic [AW-1:0] acc_idx;

  assign req_ready = (state == ST_IDLE) && !halt_sys;
  assign busy      = (state != ST_IDLE);

  // With zero wait states the access uses the live request on the capture edge.
  always_comb begin
    acc_addr  = (state == ST_IDLE) ? req_addr  : cap_addr;
    acc_wdata = (state == ST_IDLE) ? req_wdata : cap_wdata;
    acc_write = (state == ST_IDLE) ? req_write : cap_write;
    acc_err   = ({1'b0, acc_addr} >= 17'(DEPTH));
    acc_idx   = acc_addr[AW-1:0];
    acc_now   = !halt_sys &&
                (((state == ST_IDLE) && req_valid && (WAIT == 0)) ||
                 ((state == ST_WAIT) && (cnt == 4'd1)));
  end

  // Array is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (acc_now && acc_write && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      cap_addr  <= 16'h0000;
      cap_wdata <= 16'h0000;
      cap_write <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'h0000;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (!halt_sys) begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_write <= req_write;
            if (WAIT == 0) begin
              state <= ST_RESP;
            end else begin
              cnt   <= 4'(WAIT);
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (acc_now) begin
        rsp_valid <= 1'b1;
        rsp_write <= acc_write;
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_write || acc_err) ? 16'h0000 : mem[acc_idx];
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized scoreboard bench for mem_responder
module tb_mem_responder;
  localparam int DEPTH = 256;
  localparam int WAIT  = 2;
  localparam int ZDEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        halt_sys = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_write, rsp_err, busy;
  logic [15:0] rsp_rdata;

  logic        z_req_valid = 1'b0;
  logic        z_req_write = 1'b0;
  logic [15:0] z_req_addr = 16'h0;
  logic [15:0] z_req_wdata = 16'h0;
  logic        z_req_ready, z_rsp_valid, z_rsp_write, z_rsp_err, z_busy;
  logic [15:0] z_rsp_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rr_mode = 0;

  typedef struct {
    logic [15:0] rdata;
    logic        write;
    logic        err;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_mem [int];
  int          known[$];

  mem_responder #(.DEPTH(DEPTH), .WAIT(WAIT)) dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_write(rsp_write), .rsp_err(rsp_err), .busy(busy)
  );

  mem_responder #(.DEPTH(ZDEPTH), .WAIT(0)) dut_z (
    .clk(clk), .rst(rst), .halt_sys(halt_sys),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(z_rsp_rdata),
    .rsp_write(z_rsp_write), .rsp_err(z_rsp_err), .busy(z_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #2;
    case (rr_mode)
      0: rsp_ready = 1'b1;
      1: rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: one request at a time, so applying each access at acceptance gives the right order.
  function automatic exp_t model(input logic w, input int a, input logic [15:0] d, input int lat);
    exp_t e;
    e.write = w;
    e.err   = (a >= DEPTH);
    e.rdata = 16'h0000;
    if (!e.err) begin
      if (w) ref_mem[a] = d;
      else   e.rdata = ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    end
    e.due = cyc + lat;
    return e;
  endfunction

  task automatic do_req(input logic w, input int a, input logic [15:0] d,
                        input int extra, input bit abort, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a[15:0];
    req_wdata = d;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        acc = cyc;
        if (!abort) exp_q.push_back(model(w, a, d, 1 + WAIT + extra));
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("req_accept", 32'(got), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  bit   in_resp = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst) begin
      in_resp = 1'b0;
    end else if (rsp_valid) begin
      if (!in_resp) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: response with empty queue at cycle %0d", cyc);
        end else begin
          cur = exp_q.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(cur.rdata));
          check("rsp_write", 32'(rsp_write), 32'(cur.write));
          check("rsp_err", 32'(rsp_err), 32'(cur.err));
          check("rsp_latency", cyc, cur.due);
        end
        in_resp = 1'b1;
      end else begin
        check("rsp_stable", {13'd0, rsp_rdata, rsp_write, rsp_err}, {13'd0, cur.rdata, cur.write, cur.err});
      end
      check("req_ready_in_resp", 32'(req_ready), 32'd0);
      if (rsp_ready && !halt_sys) in_resp = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a1, a2, a, r, zprev;
    logic w;
    logic [15:0] d;

    repeat (3) @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Write then read, plus request spacing with rsp_ready tied high
    rr_mode = 0;
    do_req(1'b1, 16'h0010, 16'hBEEF, 0, 1'b0, a1);
    do_req(1'b0, 16'h0010, 16'h0000, 0, 1'b0, a2);
    check("req_spacing", a2 - a1, WAIT + 2);
    drain();

    // Out of range write must not alias onto address 0
    do_req(1'b1, 16'h0000, 16'h5A5A, 0, 1'b0, a1);
    do_req(1'b1, 16'h0100, 16'h1234, 0, 1'b0, a1);
    do_req(1'b0, 16'h0000, 16'h0000, 0, 1'b0, a1);
    drain();

    // Back-pressure for five cycles
    rr_mode = 2;
    do_req(1'b0, 16'h0010, 16'h0000, 0, 1'b0, a1);
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    rr_mode = 0;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_release_req_ready", 32'(req_ready), 32'd1);

    // Halt for three cycles in WAIT delays the response by three
    do_req(1'b0, 16'h0010, 16'h0000, 3, 1'b0, a1);
    halt_sys = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    halt_sys = 1'b0;
    drain();

    // Reset mid-WAIT aborts a pending write
    do_req(1'b1, 16'h0020, 16'h1111, 0, 1'b0, a1);
    drain();
    do_req(1'b1, 16'h0020, 16'hDEAD, 0, 1'b1, a1);
    #1;
    rst = 1'b0;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_req(1'b0, 16'h0020, 16'h0000, 0, 1'b0, a1);
    drain();

    // Randomized mix with random back-pressure
    known.push_back(16'h0000);
    known.push_back(16'h0010);
    known.push_back(16'h0020);
    rr_mode = 1;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      d = 16'($urandom);
      if (r < 4) begin
        w = 1'b1;
        a = $urandom_range(0, DEPTH - 1);
        if (!ref_mem.exists(a)) known.push_back(a);
      end else if (r < 8) begin
        w = 1'b0;
        a = known[$urandom_range(0, known.size() - 1)];
      end else begin
        w = 1'($urandom_range(0, 1));
        a = $urandom_range(DEPTH, 65535);
      end
      do_req(w, a, d, 0, 1'b0, a1);
    end
    rr_mode = 0;
    drain();

    // Zero-wait instance: response next cycle, one request every two cycles
    zprev = -1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      z_req_valid = 1'b1;
      z_req_write = (k == 0);
      z_req_addr  = (k == 3) ? 16'd16 : 16'd3;
      z_req_wdata = 16'hC0DE;
      @(negedge clk);
      check("z_req_ready", 32'(z_req_ready), 32'd1);
      if (zprev >= 0) check("z_spacing", cyc - zprev, 2);
      zprev = cyc;
      @(negedge clk);
      check("z_rsp_valid", 32'(z_rsp_valid), 32'd1);
      check("z_rsp_write", 32'(z_rsp_write), 32'(k == 0));
      check("z_rsp_err", 32'(z_rsp_err), 32'(k == 3));
      check("z_rsp_rdata", 32'(z_rsp_rdata), (k == 1 || k == 2) ? 32'hC0DE : 32'h0);
    end
    @(posedge clk);
    #1;
    z_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("z_idle", 32'(z_busy), 32'd0);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
